// File: rtl/beat_sequencer_pkg.sv
// Shared definitions for the beat sequencer: the instruction-cycle phase
// enum, the 3-bit function codes, and the helpers that derive the beat length
// and digit-counter width from the word geometry.
package beat_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_STOP,
    PH_SCAN1,
    PH_ACTION1,
    PH_SCAN2,
    PH_ACTION2
  } phase_t;

  localparam logic [2:0] FN_JMP     = 3'b000;
  localparam logic [2:0] FN_JRP     = 3'b001;
  localparam logic [2:0] FN_LDN     = 3'b010;
  localparam logic [2:0] FN_STO     = 3'b011;
  localparam logic [2:0] FN_SUB     = 3'b100;
  localparam logic [2:0] FN_SUB_ALT = 3'b101;
  localparam logic [2:0] FN_CMP     = 3'b110;
  localparam logic [2:0] FN_STP     = 3'b111;

  function automatic int beat_len(input int instr_bits, input int flyback);
    return instr_bits + flyback;
  endfunction

  function automatic int digit_w(input int instr_bits, input int flyback);
    return $clog2(instr_bits + flyback) + 1;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Free-running digit counter for one beat, plus the end-of-beat decode.
// Ports:
//   clk   - digit clock
//   rst   - synchronous active-high reset
//   digit - current digit, 0..BEAT_LEN-1, wraps to 0
//   xtb   - high on the last digit of the beat
module beat_counter
  import beat_sequencer_pkg::*;
#(
  parameter int INSTR_BITS   = 20,
  parameter int FLYBACK_TIME = 4,
  localparam int BEAT_LEN    = beat_len(INSTR_BITS, FLYBACK_TIME),
  localparam int DW          = digit_w(INSTR_BITS, FLYBACK_TIME)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] digit,
  output logic          xtb
);

  localparam logic [DW-1:0] LAST = DW'(BEAT_LEN - 1);

  assign xtb = (digit == LAST);

  always_ff @(posedge clk) begin
    if (rst)      digit <= '0;
    else if (xtb) digit <= '0;
    else          digit <= digit + 1'b1;
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat and phase controller for the serial accumulator datapath.
// Steps STOP -> SCAN1 -> ACTION1 -> SCAN2 -> ACTION2 on beat boundaries,
// latches the function bits at the end of ACTION1 and drives the
// accumulator control lines and control-instruction increment pulses.
// Ports:
//   w_CLK, w_RST   - digit clock, synchronous active-high reset
//   w_RUN          - continuous-run level
//   w_KCC          - single-shot request pulse (honoured only in STOP)
//   b_FUNC         - instruction bits 13..15, sampled on ACTION1 end-of-beat
//   w_A_SIGN       - serial accumulator output, sign digit sampled for CMP
//   b_DIGIT, w_XTB - digit number and end-of-beat pulse
//   w_ACTION_WF    - low only during ACTION2
//   w_INSTR_1_14/15- latched function bits 1 and 2
//   w_A_ZERO       - read-zero force during ACTION2 of LDN
//   w_CI_INC       - control-instruction increment pulse
//   w_STOPPED      - high in STOP
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int INSTR_BITS   = 20,
  parameter int FLYBACK_TIME = 4,
  localparam int DW          = digit_w(INSTR_BITS, FLYBACK_TIME)
) (
  input  logic          w_CLK,
  input  logic          w_RST,
  input  logic          w_RUN,
  input  logic          w_KCC,
  input  logic [2:0]    b_FUNC,
  input  logic          w_A_SIGN,
  output logic [DW-1:0] b_DIGIT,
  output logic          w_XTB,
  output logic          w_ACTION_WF,
  output logic          w_INSTR_1_14,
  output logic          w_INSTR_1_15,
  output logic          w_A_ZERO,
  output logic          w_CI_INC,
  output logic          w_STOPPED
);

  localparam logic [DW-1:0] SIGN_DIGIT = DW'(INSTR_BITS - 1);

  phase_t     phase, phase_nxt;
  logic       pending;   // KCC seen in STOP, waiting for the boundary
  logic       hold;      // stopped by STP: RUN must drop before it restarts us
  logic       skip;      // CMP saw a negative accumulator
  logic [2:0] func_lat;
  logic       start;

  beat_counter #(
    .INSTR_BITS  (INSTR_BITS),
    .FLYBACK_TIME(FLYBACK_TIME)
  ) u_cnt (
    .clk  (w_CLK),
    .rst  (w_RST),
    .digit(b_DIGIT),
    .xtb  (w_XTB)
  );

  // Raw w_KCC is included so a request on the boundary digit itself is taken.
  assign start = pending | w_KCC | (w_RUN & ~hold);

  always_comb begin
    phase_nxt = phase;
    if (w_XTB) begin
      unique case (phase)
        PH_STOP:    if (start) phase_nxt = PH_SCAN1;
        PH_SCAN1:   phase_nxt = PH_ACTION1;
        PH_ACTION1: phase_nxt = PH_SCAN2;
        PH_SCAN2:   phase_nxt = PH_ACTION2;
        PH_ACTION2: phase_nxt = (func_lat == FN_STP || !w_RUN) ? PH_STOP : PH_SCAN1;
        default:    phase_nxt = PH_STOP;
      endcase
    end
  end

  always_ff @(posedge w_CLK) begin
    if (w_RST) begin
      phase    <= PH_STOP;
      pending  <= 1'b0;
      hold     <= 1'b0;
      skip     <= 1'b0;
      func_lat <= FN_JMP;
    end else begin
      phase <= phase_nxt;
      if (phase == PH_STOP) begin
        if (w_XTB && start) begin
          pending <= 1'b0;
          hold    <= 1'b0;
        end else begin
          if (w_KCC)  pending <= 1'b1;
          if (!w_RUN) hold    <= 1'b0;
        end
      end
      if (phase == PH_ACTION1 && w_XTB)
        func_lat <= b_FUNC;
      if (phase == PH_ACTION2 && func_lat == FN_CMP && b_DIGIT == SIGN_DIGIT && w_A_SIGN)
        skip <= 1'b1;
      // End of ACTION2: skip is consumed by the pulse on this digit.
      if (phase == PH_ACTION2 && w_XTB) begin
        skip <= 1'b0;
        if (func_lat == FN_STP) hold <= 1'b1;
      end
    end
  end

  assign w_STOPPED    = (phase == PH_STOP);
  assign w_ACTION_WF  = (phase != PH_ACTION2);
  assign w_A_ZERO     = (phase == PH_ACTION2) && (func_lat == FN_LDN);
  assign w_CI_INC     = w_XTB && ((phase == PH_SCAN1) || (phase == PH_ACTION2 && skip));
  assign w_INSTR_1_14 = func_lat[1];
  assign w_INSTR_1_15 = func_lat[2];

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: a beat-level reference model is
// compared against every output each cycle, plus a table of single-shot
// instruction scenarios and hand-written multi-cycle corner sequences.
module tb_beat_sequencer;

  localparam int IB = 20;
  localparam int FB = 4;
  localparam int BL = IB + FB;
  localparam int DW = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          rst, run, kcc, sgn;
  logic [2:0]    func;
  logic [DW-1:0] b_DIGIT;
  logic          w_XTB, w_ACTION_WF, w_INSTR_1_14, w_INSTR_1_15, w_A_ZERO, w_CI_INC, w_STOPPED;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  beat_sequencer #(.INSTR_BITS(IB), .FLYBACK_TIME(FB)) dut (
    .w_CLK(clk), .w_RST(rst), .w_RUN(run), .w_KCC(kcc), .b_FUNC(func), .w_A_SIGN(sgn),
    .b_DIGIT(b_DIGIT), .w_XTB(w_XTB), .w_ACTION_WF(w_ACTION_WF),
    .w_INSTR_1_14(w_INSTR_1_14), .w_INSTR_1_15(w_INSTR_1_15),
    .w_A_ZERO(w_A_ZERO), .w_CI_INC(w_CI_INC), .w_STOPPED(w_STOPPED)
  );

  // Reference model. Phases: 0 STOP, 1 SCAN1, 2 ACTION1, 3 SCAN2, 4 ACTION2.
  typedef struct {
    int         digit;
    int         ph;
    bit         pend;
    bit         hold;
    bit         skip;
    logic [2:0] func;
  } model_t;

  model_t m = '{0, 0, 1'b0, 1'b0, 1'b0, 3'b000};

  function automatic model_t step(model_t c, logic r, logic rn, logic k, logic [2:0] f, logic s);
    model_t n = c;
    bit boundary = (c.digit == BL - 1);
    if (r) begin
      n = '{0, 0, 1'b0, 1'b0, 1'b0, 3'b000};
      return n;
    end
    n.digit = (c.digit + 1) % BL;
    if (c.ph == 0) begin
      if (k) n.pend = 1'b1;
      if (!rn) n.hold = 1'b0;
      if (boundary && (c.pend || k || (rn && !c.hold))) begin
        n.ph = 1; n.pend = 1'b0; n.hold = 1'b0;
      end
    end else if (c.ph == 4) begin
      if (c.func == 3'b110 && c.digit == IB - 1 && s) n.skip = 1'b1;
      if (boundary) begin
        n.skip = 1'b0;
        if (c.func == 3'b111 || !rn) begin
          n.ph = 0; n.hold = (c.func == 3'b111);
        end else n.ph = 1;
      end
    end else if (boundary) begin
      if (c.ph == 2) n.func = f;
      n.ph = c.ph + 1;
    end
    return n;
  endfunction

  function automatic logic [DW+6:0] exp_vec(model_t x);
    bit xtb = (x.digit == BL - 1);
    return {DW'(x.digit), xtb, (x.ph != 4), x.func[1], x.func[2],
            (x.ph == 4 && x.func == 3'b010),
            (xtb && (x.ph == 1 || (x.ph == 4 && x.skip))), (x.ph == 0)};
  endfunction

  always @(posedge clk) m <= step(m, rst, run, kcc, func, sgn);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock; compares the whole output vector against the model.
  task automatic tick();
    logic [DW+6:0] act;
    @(negedge clk);
    if (mon_en) begin
      act = {b_DIGIT, w_XTB, w_ACTION_WF, w_INSTR_1_14, w_INSTR_1_15, w_A_ZERO, w_CI_INC, w_STOPPED};
      checks++;
      if (act !== exp_vec(m)) begin
        errors++;
        $display("FAIL model_cmp: got %b expected %b at t=%0t", act, exp_vec(m), $time);
      end
    end
  endtask

  task automatic wait_stop(input logic want, input int lim, input string nm);
    for (int i = 0; i < lim; i++) begin
      if (w_STOPPED == want) break;
      tick();
    end
    chk(nm, w_STOPPED, want);
  endtask

  typedef struct {
    logic [2:0] f;
    logic       s;
    int         ci;
    int         az;
    logic       i14;
    logic       i15;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int busy, ci, az, wfl, cnt, found;
    rst = 1'b1; run = 1'b0; kcc = 1'b0; func = 3'b000; sgn = 1'b0;
    mon_en = 1'b1;
    tick(); tick();
    chk("rst_digit", b_DIGIT, 0);
    chk("rst_stopped", w_STOPPED, 1);
    chk("rst_wf", w_ACTION_WF, 1);
    chk("rst_xtb", w_XTB, 0);
    chk("rst_ci", w_CI_INC, 0);
    chk("rst_azero", w_A_ZERO, 0);
    chk("rst_i14_i15", {w_INSTR_1_14, w_INSTR_1_15}, 0);
    rst = 1'b0;

    // Idle: XTB every BEAT_LEN clocks, never leaves STOP, no increments.
    cnt = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (n == 23 || n == 47 || n == 71) chk("idle_xtb_hi", w_XTB, 1);
      if (n == 24 || n == 46) chk("idle_xtb_lo", w_XTB, 0);
      if (!w_STOPPED || w_CI_INC) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // Single-shot KCC instructions from STOP.
    tbl[0] = '{3'b010, 1'b0, 1, 24, 1'b1, 1'b0};
    tbl[1] = '{3'b110, 1'b1, 2,  0, 1'b1, 1'b1};
    tbl[2] = '{3'b110, 1'b0, 1,  0, 1'b1, 1'b1};
    tbl[3] = '{3'b111, 1'b1, 1,  0, 1'b1, 1'b1};
    tbl[4] = '{3'b100, 1'b1, 1,  0, 1'b0, 1'b1};
    tbl[5] = '{3'b001, 1'b0, 1,  0, 1'b0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      found = 0;
      for (int i = 0; i < 60; i++) begin
        if (w_STOPPED && b_DIGIT == 5) begin found = 1; break; end
        tick();
      end
      chk("kcc_align", found, 1);
      func = tbl[t].f; sgn = tbl[t].s; kcc = 1'b1;
      tick();
      kcc = 1'b0;
      busy = 0; ci = 0; az = 0; wfl = 0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (!w_STOPPED) begin
          busy++; ci += int'(w_CI_INC); az += int'(w_A_ZERO); wfl += int'(!w_ACTION_WF);
        end else if (busy > 0) break;
      end
      chk($sformatf("tbl%0d_busy", t), busy, 4 * BL);
      chk($sformatf("tbl%0d_ci", t), ci, tbl[t].ci);
      chk($sformatf("tbl%0d_azero", t), az, tbl[t].az);
      chk($sformatf("tbl%0d_wf_low", t), wfl, BL);
      chk($sformatf("tbl%0d_i14", t), w_INSTR_1_14, tbl[t].i14);
      chk($sformatf("tbl%0d_i15", t), w_INSTR_1_15, tbl[t].i15);
    end

    // KCC on the boundary digit is taken at that same boundary.
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (w_STOPPED && w_XTB) begin found = 1; break; end
      tick();
    end
    chk("kcc_xtb_align", found, 1);
    func = 3'b000; kcc = 1'b1;
    tick();
    kcc = 1'b0;
    chk("kcc_xtb_started", w_STOPPED, 0);
    chk("kcc_xtb_digit", b_DIGIT, 0);
    wait_stop(1'b1, 200, "kcc_xtb_done");

    // STP with RUN held high halts and stays halted.
    func = 3'b111; run = 1'b1;
    wait_stop(1'b0, 30, "stp_start");
    wait_stop(1'b1, 200, "stp_halt");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!w_STOPPED) cnt++;
    end
    chk("stp_hold", cnt, 0);

    // RUN low then high restarts; SUB runs continuously.
    run = 1'b0; tick(); tick();
    run = 1'b1; func = 3'b100;
    wait_stop(1'b0, 30, "run_restart");
    for (int i = 0; i < 60; i++) tick();
    chk("sub_i15", w_INSTR_1_15, 1);
    chk("sub_i14", w_INSTR_1_14, 0);
    cnt = 0;
    for (int i = 0; i < 4 * BL; i++) begin
      tick();
      if (w_STOPPED) cnt++;
    end
    chk("run_continuous", cnt, 0);
    // RUN falls mid-instruction: finishes ACTION2 then stops.
    run = 1'b0;
    wait_stop(1'b1, 200, "run_fall_stop");

    // Reset in the middle of ACTION2 of LDN.
    func = 3'b010; kcc = 1'b1;
    tick();
    kcc = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (!w_ACTION_WF && b_DIGIT == 10) begin found = 1; break; end
      tick();
    end
    chk("rst_mid_reach", found, 1);
    chk("rst_mid_azero_pre", w_A_ZERO, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_digit", b_DIGIT, 0);
    chk("rst_mid_stopped", w_STOPPED, 1);
    chk("rst_mid_wf", w_ACTION_WF, 1);
    chk("rst_mid_azero", w_A_ZERO, 0);
    chk("rst_mid_i14", w_INSTR_1_14, 0);
    chk("rst_mid_ci_xtb", {w_CI_INC, w_XTB}, 0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      kcc  = ($urandom_range(0, 39) == 0);
      func = 3'($urandom);
      sgn  = 1'($urandom);
    end
    rst = 1'b0; run = 1'b0; kcc = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
